// File: rtl/cpx2real_upconv_pkg.sv
// Shared constants, FSM encoding and the Q1.15 round/saturate helper for the
// complex-to-real upconverter.
package cpx2real_upconv_pkg;

  localparam int DW   = 16;
  localparam int PW   = 24;
  localparam int LUTW = 8;
  localparam int QN   = 2 ** (LUTW - 2);
  localparam int FRAC = 15;

  localparam logic signed [DW-1:0]   ONE  = DW'(2 ** (DW - 1) - 1);
  localparam logic signed [DW-1:0]   MINV = DW'(-(2 ** (DW - 1)));
  localparam logic signed [2*DW:0]   RND  = (2*DW+1)'(2 ** (FRAC - 1));
  localparam logic signed [2*DW:0]   YMAX = (2*DW+1)'(2 ** (DW - 1) - 1);
  localparam logic signed [2*DW:0]   YMIN = (2*DW+1)'(-(2 ** (DW - 1)));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOOK  = 3'd1,
    S_MUL_I = 3'd2,
    S_MUL_Q = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  typedef struct packed {
    logic                 clip;
    logic signed [DW-1:0] y;
  } rs_t;

  // Round half-up at the Q1.15 point, then clamp to the DW-bit signed range.
  function automatic rs_t round_sat(input logic signed [2*DW:0] s);
    logic signed [2*DW:0] t;
    rs_t r;
    t      = (s + RND) >>> FRAC;
    r.clip = (t > YMAX) || (t < YMIN);
    if (t > YMAX)      r.y = ONE;
    else if (t < YMIN) r.y = MINV;
    else               r.y = t[DW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/cpx2real_upconv_if.sv
// Sample-side bus of the upconverter: baseband input strobe, passband output
// strobe, sticky status flags and FSM state for observation.
interface cpx2real_upconv_if;
  import cpx2real_upconv_pkg::*;

  // data_rdy is a one-cycle valid with no ready: a strobe that lands while the
  // block is busy is dropped and flagged on overrun. tx_rdy is a one-cycle valid
  // with no back-pressure; x_tx holds its value between strobes.
  logic                 data_rdy;
  logic signed [DW-1:0] re;
  logic signed [DW-1:0] im;
  logic [PW-1:0]        phase_inc;
  logic signed [DW-1:0] x_tx;
  logic                 tx_rdy;
  logic                 sat;
  logic                 overrun;
  state_t               dbg_state;

  modport master (
    output data_rdy, re, im, phase_inc,
    input  x_tx, tx_rdy, sat, overrun, dbg_state
  );

  modport slave (
    input  data_rdy, re, im, phase_inc,
    output x_tx, tx_rdy, sat, overrun, dbg_state
  );

endinterface

// File: rtl/cpx2real_upconv_sine_qlut.sv
// Registered sine/cosine lookup built from a quarter-wave ROM (0..pi/2 inclusive)
// with mirror/negate folding; one clock of latency.
module sine_qlut
  import cpx2real_upconv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LUTW-1:0]      idx,
  output logic signed [DW-1:0] sin,
  output logic signed [DW-1:0] cos
);

  // round(32767*sin(2*pi*k/256)), k = 0..64; sized for LUTW = 8.
  localparam int QTAB [QN+1] = '{
        0,   804,  1608,  2410,  3212,  4011,  4808,  5602,
     6393,  7179,  7962,  8739,  9512, 10278, 11039, 11793,
    12539, 13279, 14010, 14732, 15446, 16151, 16846, 17530,
    18204, 18868, 19519, 20159, 20787, 21403, 22005, 22594,
    23170, 23731, 24279, 24811, 25329, 25832, 26319, 26790,
    27245, 27683, 28105, 28510, 28898, 29268, 29621, 29956,
    30273, 30571, 30852, 31113, 31356, 31580, 31785, 31971,
    32137, 32285, 32412, 32521, 32609, 32678, 32728, 32757,
    32767
  };

  function automatic logic signed [DW-1:0] fold(input logic [LUTW-1:0] i);
    logic [LUTW-2:0]      off;
    logic [LUTW-2:0]      k;
    logic signed [DW-1:0] m;
    off = {1'b0, i[LUTW-3:0]};
    k   = i[LUTW-2] ? ((LUTW-1)'(QN) - off) : off;
    m   = DW'(QTAB[k]);
    return i[LUTW-1] ? -m : m;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sin <= '0;
      cos <= '0;
    end else begin
      sin <= fold(idx);
      cos <= fold(idx + LUTW'(QN));
    end
  end

endmodule

// File: rtl/cpx2real_upconv.sv
// Complex baseband to real passband mixer: x_tx = re*cos(ph) - im*sin(ph), with a
// phase-accumulator NCO and a single multiplier time-shared by a 5-state FSM.
module cpx2real_upconv
  import cpx2real_upconv_pkg::*;
(
  input logic               clk,
  input logic               reset,
  cpx2real_upconv_if.slave  bus
);

  state_t state_q, state_d;

  logic accept, drop, ld_pi, ld_pq, ld_out, sel_q;

  logic [PW-1:0]          acc_q;
  logic [LUTW-1:0]        idx_q;
  logic signed [DW-1:0]   re_q, im_q;
  logic signed [2*DW-1:0] p_i_q, p_q_q;
  logic signed [DW-1:0]   x_tx_q;
  logic                   tx_rdy_q, sat_q, overrun_q;

  logic signed [DW-1:0]   sin_w, cos_w;
  logic signed [DW-1:0]   mul_a, mul_b;
  logic signed [2*DW-1:0] prod;
  logic signed [2*DW:0]   s_w;
  rs_t                    rs;

  sine_qlut u_lut (
    .clk   (clk),
    .reset (reset),
    .idx   (idx_q),
    .sin   (sin_w),
    .cos   (cos_w)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.data_rdy) state_d = S_LOOK;
      S_LOOK:  state_d = S_MUL_I;
      S_MUL_I: state_d = S_MUL_Q;
      S_MUL_Q: state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    ld_pi  = 1'b0;
    ld_pq  = 1'b0;
    ld_out = 1'b0;
    sel_q  = 1'b0;
    case (state_q)
      S_IDLE:  accept = bus.data_rdy;
      S_MUL_I: ld_pi  = 1'b1;
      S_MUL_Q: begin
        ld_pq = 1'b1;
        sel_q = 1'b1;
      end
      S_OUT:   ld_out = 1'b1;
      default: ;
    endcase
    drop = bus.data_rdy && (state_q != S_IDLE);
  end

  // The one multiplier: re*cos in MUL_I, im*sin in MUL_Q.
  assign mul_a = sel_q ? im_q  : re_q;
  assign mul_b = sel_q ? sin_w : cos_w;
  assign prod  = (2*DW)'(mul_a) * (2*DW)'(mul_b);

  assign s_w = (2*DW+1)'(p_i_q) - (2*DW+1)'(p_q_q);
  assign rs  = round_sat(s_w);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      idx_q     <= '0;
      re_q      <= '0;
      im_q      <= '0;
      p_i_q     <= '0;
      p_q_q     <= '0;
      x_tx_q    <= '0;
      tx_rdy_q  <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        re_q  <= bus.re;
        im_q  <= bus.im;
        idx_q <= acc_q[PW-1 -: LUTW];
        acc_q <= acc_q + bus.phase_inc;
      end
      if (ld_pi) p_i_q <= prod;
      if (ld_pq) p_q_q <= prod;
      if (ld_out) begin
        x_tx_q <= rs.y;
        sat_q  <= sat_q | rs.clip;
      end
      tx_rdy_q  <= ld_out;
      overrun_q <= overrun_q | drop;
    end
  end

  assign bus.x_tx      = x_tx_q;
  assign bus.tx_rdy    = tx_rdy_q;
  assign bus.sat       = sat_q;
  assign bus.overrun   = overrun_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cpx2real_upconv.sv
// Self-checking bench for cpx2real_upconv: reference NCO/mixer built from $sin,
// expected samples and arrival cycles queued at drive time.
module tb_cpx2real_upconv;
  import cpx2real_upconv_pkg::*;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cpx2real_upconv_if bus ();

  cpx2real_upconv dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // scoreboard state
  logic signed [DW-1:0] exp_q[$];
  int                   exp_c_q[$];
  int                   n_checks = 0;
  int                   n_pass   = 0;
  logic [PW-1:0]        acc_m    = '0;
  int                   last_acc = -100;
  logic                 sat_m    = 1'b0;
  logic                 ovr_m    = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int ref_sin(input int i);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(i) / real'(1 << LUTW));
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic int ref_x(input int r, input int i, input int idx, output int clip);
    longint s, t;
    s = longint'(r) * ref_sin((idx + QN) % (1 << LUTW)) - longint'(i) * ref_sin(idx);
    t = (s + 16384) >>> 15;
    clip = (t > 32767 || t < -32768) ? 1 : 0;
    if (t > 32767)  return 32767;
    if (t < -32768) return -32768;
    return int'(t);
  endfunction

  // driver: call at a negedge; strobe lasts one cycle, next call `gap` cycles later
  task automatic send(input int r, input int i, input logic [PW-1:0] inc, input int gap);
    int e, y, clip;
    bus.data_rdy  = 1'b1;
    bus.re        = DW'(r);
    bus.im        = DW'(i);
    bus.phase_inc = inc;
    e = cyc + 1;
    if (e >= last_acc + 5) begin
      y = ref_x(r, i, int'(acc_m[PW-1 -: LUTW]), clip);
      exp_q.push_back(DW'(y));
      exp_c_q.push_back(e + 4);
      if (clip != 0) sat_m = 1'b1;
      acc_m    = acc_m + inc;
      last_acc = e;
    end else begin
      ovr_m = 1'b1;
    end
    @(negedge clk);
    bus.data_rdy = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_x_tx"},    bus.x_tx,    0);
    check({tag, "_tx_rdy"},  bus.tx_rdy,  0);
    check({tag, "_sat"},     bus.sat,     0);
    check({tag, "_overrun"}, bus.overrun, 0);
    exp_q.delete();
    exp_c_q.delete();
    acc_m    = '0;
    last_acc = -100;
    sat_m    = 1'b0;
    ovr_m    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  // monitor: compare every output strobe with the head of the queue
  always @(negedge clk) begin
    if (rst_n && bus.tx_rdy) begin
      if (exp_q.size() == 0) begin
        check("tx_spurious", 1, 0);
      end else begin
        check("x_tx", bus.x_tx, exp_q.pop_front());
        check("tx_cycle", cyc, exp_c_q.pop_front());
      end
    end
  end

  initial begin
    bus.data_rdy  = 1'b0;
    bus.re        = '0;
    bus.im        = '0;
    bus.phase_inc = '0;
    @(negedge clk);
    do_reset("rst0");

    // constant phase 0
    send(1000, 500, '0, 20);
    drain("t1");
    check("t1_x_tx", bus.x_tx, 1000);
    check("t1_sat", bus.sat, 0);

    // quarter-turn steps: 1000, 0, -1000, 0
    for (int k = 0; k < 4; k++) send(1000, 0, PW'(1) << (PW - 2), 20);
    drain("t2");
    check("t2_last_x_tx", bus.x_tx, 0);

    // full-scale inputs, second sample at 45 degrees clips
    send(-32768, 32767, PW'(1) << (PW - 3), 20);
    check("t3_first", bus.x_tx, -32767);
    check("t3_sat_before", bus.sat, 0);
    send(-32768, 32767, PW'(1) << (PW - 3), 20);
    check("t3_second", bus.x_tx, -32768);
    check("t3_sat", bus.sat, 1);
    send(100, 100, '0, 20);
    check("t3_sat_sticky", bus.sat, 1);
    check("t3_no_overrun", bus.overrun, 0);

    // strobe while busy is dropped
    send(100, 200, 24'h123456, 2);
    send(300, 400, 24'h123456, 18);
    send(500, -600, 24'h123456, 20);
    drain("t4");
    check("t4_overrun", bus.overrun, 1);

    // reset while a sample is in flight
    send(2000, -3000, 24'h300000, 2);
    do_reset("t5_rst");
    send(700, -900, 24'h0A3D71, 20);
    drain("t5");
    check("t5_x_tx", bus.x_tx, 700);

    // random sweep, occasional short gaps
    for (int k = 0; k < 200; k++)
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           24'h0A3D71, int'($urandom_range(3, 9)));
    drain("sweep");
    check("sweep_sat", bus.sat, longint'(sat_m));
    check("sweep_overrun", bus.overrun, longint'(ovr_m));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
